// File: rtl/timer_arbiter.sv
// timer_arbiter
//   Shares one 12-bit down-counter among four requesters. An idle arbiter
//   grants the next requester in round-robin order and loads that
//   requester's count. The counter steps down on tick_i. At zero, a
//   one-cycle done pulse goes to the owner. If the owner drops its
//   request while counting, the countdown is abandoned without a pulse.
//
// Ports
//   clk_i      system clock, rising edge
//   rst_i      asynchronous active-high reset
//   tick_i     count enable for the running countdown
//   req_i      per-requester request, held until done or abort
//   count_i    four 12-bit load values, requester i at [12i+11:12i]
//   grant_o    one-hot owner of the counter, zero when idle
//   done_o     one-cycle expiry pulse to the owner
//   busy_o     high while counting or expiring
//   counter_o  current counter value
//   zero_o     counter_o == 0
//
// state    | meaning
// S_IDLE   | no owner; arbitrate among pending requests
// S_COUNT  | owner granted; counter steps down on tick_i
// S_EXPIRE | done pulse to owner; release on next edge
module timer_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        tick_i,
    input  logic [3:0]  req_i,
    input  logic [47:0] count_i,
    output logic [3:0]  grant_o,
    output logic [3:0]  done_o,
    output logic        busy_o,
    output logic [11:0] counter_o,
    output logic        zero_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_COUNT  = 2'd1,
        S_EXPIRE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  done_q, done_d;
    logic [1:0]  gidx_q, gidx_d;
    logic [1:0]  ptr_q, ptr_d;
    logic [11:0] counter_q, counter_d;

    logic        found;
    logic [1:0]  sel;
    logic [1:0]  cand;
    logic [11:0] load_val;
    logic        cnt_zero;

    assign cnt_zero = (counter_q == 12'd0);

    // Round-robin search starting at ptr_q. The 2-bit index wraps modulo 4.
    always_comb begin
        found = 1'b0;
        sel   = 2'd0;
        cand  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            cand = ptr_q + 2'(k);
            if (!found && req_i[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    load_val = count_i[11:0];
            2'd1:    load_val = count_i[23:12];
            2'd2:    load_val = count_i[35:24];
            default: load_val = count_i[47:36];
        endcase
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        counter_d = counter_q;
        done_d    = 4'b0000;

        case (state_q)
            S_IDLE: begin
                grant_d = 4'b0000;
                if (found) begin
                    state_d   = S_COUNT;
                    grant_d   = 4'b0001 << sel;
                    gidx_d    = sel;
                    counter_d = load_val;
                end
            end

            S_COUNT: begin
                if (!req_i[gidx_q]) begin
                    // Abort: release the counter, leave its value, no pulse.
                    state_d = S_IDLE;
                    grant_d = 4'b0000;
                    ptr_d   = gidx_q + 2'd1;
                end else if (cnt_zero) begin
                    // Register the pulse here so done_o is high exactly in EXPIRE.
                    state_d = S_EXPIRE;
                    done_d  = grant_q;
                end else if (tick_i) begin
                    counter_d = counter_q - 12'd1;
                end
            end

            S_EXPIRE: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
                ptr_d   = gidx_q + 2'd1;
            end

            default: begin
                state_d = S_IDLE;
                grant_d = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            grant_q   <= 4'b0000;
            done_q    <= 4'b0000;
            gidx_q    <= 2'd0;
            ptr_q     <= 2'd0;
            counter_q <= 12'd0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            gidx_q    <= gidx_d;
            ptr_q     <= ptr_d;
            counter_q <= counter_d;
        end
    end

    assign grant_o   = grant_q;
    assign done_o    = done_q;
    assign busy_o    = (state_q != S_IDLE);
    assign counter_o = counter_q;
    assign zero_o    = cnt_zero;

endmodule

// File: tb/tb_timer_arbiter.sv
module tb_timer_arbiter;

    logic        clk_i;
    logic        rst_i;
    logic        tick_i;
    logic [3:0]  req_i;
    logic [47:0] count_i;
    logic [3:0]  grant_o;
    logic [3:0]  done_o;
    logic        busy_o;
    logic [11:0] counter_o;
    logic        zero_o;

    int n_checks = 0;
    int n_errors = 0;
    int done_cnt = 0;

    timer_arbiter dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .tick_i    (tick_i),
        .req_i     (req_i),
        .count_i   (count_i),
        .grant_o   (grant_o),
        .done_o    (done_o),
        .busy_o    (busy_o),
        .counter_o (counter_o),
        .zero_o    (zero_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to the next falling edge, with exactly one rising edge in between.
    task automatic cyc();
        @(negedge clk_i);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " grant"}, 32'(grant_o), 32'h0);
        chk({tag, " busy"},  32'(busy_o),  32'h0);
        chk({tag, " done"},  32'(done_o),  32'h0);
    endtask

    initial begin
        rst_i   = 1'b1;
        tick_i  = 1'b0;
        req_i   = 4'b0000;
        count_i = 48'd0;

        // Reset state
        cyc();
        chk_idle("reset");
        chk("reset counter", 32'(counter_o), 32'h0);
        chk("reset zero",    32'(zero_o),    32'h1);

        // Single request, load 8, tick always high
        rst_i          = 1'b0;
        tick_i         = 1'b1;
        count_i[11:0]  = 12'o0010;
        req_i          = 4'b0001;
        cyc();
        chk("single grant",   32'(grant_o),   32'h1);
        chk("single counter", 32'(counter_o), 32'd8);
        chk("single busy",    32'(busy_o),    32'h1);
        for (int k = 1; k <= 8; k++) begin
            cyc();
            chk("single count", 32'(counter_o), 32'(8 - k));
            chk("single nodone", 32'(done_o), 32'h0);
        end
        cyc();
        chk("single done", 32'(done_o), 32'h1);
        chk("single busy expire", 32'(busy_o), 32'h1);
        req_i = 4'b0000;
        cyc();
        chk_idle("single release");

        // Round robin from reset, all loads 1
        #2 rst_i = 1'b1;
        #1 chk_idle("rr reset");
        cyc();
        rst_i   = 1'b0;
        count_i = {12'd1, 12'd1, 12'd1, 12'd1};
        req_i   = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rr grant", 32'(grant_o), 32'(4'b0001 << i));
            chk("rr load",  32'(counter_o), 32'd1);
            if (done_o != 4'b0000) done_cnt++;
            cyc();
            chk("rr count0", 32'(counter_o), 32'd0);
            chk("rr nodone", 32'(done_o), 32'h0);
            if (done_o != 4'b0000) done_cnt++;
            cyc();
            chk("rr done", 32'(done_o), 32'(4'b0001 << i));
            if (done_o != 4'b0000) done_cnt++;
            req_i[i] = 1'b0;
            cyc();
            chk_idle("rr idle");
            if (done_o != 4'b0000) done_cnt++;
        end
        chk("rr done pulses", 32'(done_cnt), 32'd4);

        // Tick gating, requester 1 with load 3
        tick_i         = 1'b0;
        count_i[23:12] = 12'd3;
        req_i          = 4'b0010;
        cyc();
        chk("gate grant", 32'(grant_o),   32'h2);
        chk("gate load",  32'(counter_o), 32'd3);
        for (int j = 1; j <= 6; j++) begin
            tick_i = ((j % 2) == 0);
            cyc();
            chk("gate count", 32'(counter_o), 32'(3 - j / 2));
            chk("gate nodone", 32'(done_o), 32'h0);
        end
        tick_i = 1'b0;
        cyc();
        chk("gate done", 32'(done_o), 32'h2);
        req_i = 4'b0000;
        cyc();
        chk_idle("gate release");

        // Abort requester 2 at counter 5 while requester 3 waits
        tick_i         = 1'b1;
        count_i[35:24] = 12'o0020;
        req_i          = 4'b0100;
        cyc();
        chk("abort grant", 32'(grant_o),   32'h4);
        chk("abort load",  32'(counter_o), 32'd16);
        req_i          = 4'b1100;
        count_i[47:36] = 12'd7;
        count_i[35:24] = 12'h0AB;   // must not disturb the running countdown
        for (int j = 1; j <= 11; j++) begin
            cyc();
            chk("abort count", 32'(counter_o), 32'(16 - j));
            chk("abort owner", 32'(grant_o), 32'h4);
        end
        req_i = 4'b1000;
        cyc();
        chk_idle("abort idle");
        chk("abort counter kept", 32'(counter_o), 32'd5);
        cyc();
        chk("abort next grant", 32'(grant_o),   32'h8);
        chk("abort next load",  32'(counter_o), 32'd7);
        chk("abort no done2",   32'(done_o),    32'h0);

        // Reset mid-count at counter 4
        cyc();
        cyc();
        cyc();
        chk("midrst pre counter", 32'(counter_o), 32'd4);
        #2 rst_i = 1'b1;
        #1;
        chk_idle("midrst");
        chk("midrst counter", 32'(counter_o), 32'h0);
        chk("midrst zero",    32'(zero_o),    32'h1);
        cyc();
        chk("midrst nodone", 32'(done_o), 32'h0);
        rst_i = 1'b0;
        req_i = 4'b1010;
        cyc();
        chk("postrst grant", 32'(grant_o), 32'h2);
        req_i = 4'b0000;
        cyc();
        chk_idle("postrst abort");

        // Zero load on requester 0
        count_i[11:0] = 12'd0;
        req_i         = 4'b0001;
        cyc();
        chk("zload grant",  32'(grant_o), 32'h1);
        chk("zload zero",   32'(zero_o),  32'h1);
        chk("zload nodone", 32'(done_o),  32'h0);
        cyc();
        chk("zload done", 32'(done_o), 32'h1);
        req_i = 4'b0000;
        cyc();
        chk_idle("zload release");

        // Full-scale load counts 4095 ticks
        count_i[11:0] = 12'o7777;
        req_i         = 4'b0001;
        cyc();
        chk("max load", 32'(counter_o), 32'd4095);
        repeat (4095) cyc();
        chk("max count0", 32'(counter_o), 32'd0);
        chk("max nodone", 32'(done_o),    32'h0);
        cyc();
        chk("max done",    32'(done_o),    32'h1);
        chk("max nowrap",  32'(counter_o), 32'd0);
        req_i = 4'b0000;
        cyc();
        chk_idle("max release");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
